id_stage: RTL and testbench

- Decode stage directly downstream of instruction fetch.
- Consumes the fetched PC/instruction pair, reads the 32-entry integer register file and decodes RV32I control fields and immediate.
- Detects load-use hazards and registers the results into the ID/EX pipeline register for the execute stage.
- Also owns the register-file write port driven by writeback.

---
 rtl/id_pkg.sv | 111 +++++++++++
 rtl/id_stage_if.sv | 56 +++++
 rtl/regfile_2r1w.sv | 51 +++++
 rtl/id_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
//------------------------------------------------------------------------------
// id_pkg
// Shared constants and types for the RV32I decode stage: opcodes, ALU
// operation encodings, immediate formats, the ID/EX record and its bubble.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package id_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  // RV32I base opcodes
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    alu_op_e           alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } idex_t;

  // A bubble clears every field, so no control can leak into execute
  localparam idex_t c_BUBBLE = '0;

  // Sign-extended immediate for the given instruction format
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                              input imm_type_e   fmt);
    logic [XLEN-1:0] v;
    v = '0;
    case (fmt)
      IMM_I: v = {{20{instr[31]}}, instr[31:20]};
      IMM_S: v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};
      IMM_U: v = {instr[31:12], 12'b0};
      IMM_J: v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                  instr[30:21], 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  // ALU op for OP / OP-IMM; funct7[5] means SUB only for register-register
  // ADD, and SRA for right shifts in both forms
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       is_op);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_if.sv
//------------------------------------------------------------------------------
// id_stage_if
// Bundles the fetch-side inputs, writeback port and ID/EX outputs of the
// decode stage. master = surrounding pipeline, slave = id_stage.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface id_stage_if;
  import id_pkg::*;

  // fetch / control inputs
  logic [XLEN-1:0]   pc_in;
  logic [31:0]       instruction;
  logic              stall_in;
  logic              flush_in;
  // writeback port
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  // outputs
  logic              hazard_stall;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  alu_op_e           alu_op;
  logic              alu_src;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              branch;
  logic              jump;
  logic              illegal;

  modport master (
    output pc_in, instruction, stall_in, flush_in, wb_en, wb_rd, wb_data,
    input  hazard_stall, id_valid, id_pc, rs1_data, rs2_data, imm, rd, rs1,
           rs2, alu_op, alu_src, reg_write, mem_read, mem_write, branch, jump,
           illegal
  );

  modport slave (
    input  pc_in, instruction, stall_in, flush_in, wb_en, wb_rd, wb_data,
    output hazard_stall, id_valid, id_pc, rs1_data, rs2_data, imm, rd, rs1,
           rs2, alu_op, alu_src, reg_write, mem_read, mem_write, branch, jump,
           illegal
  );

endinterface

`default_nettype wire

// File: rtl/regfile_2r1w.sv
//------------------------------------------------------------------------------
// regfile_2r1w
// 32 x XLEN integer register file: two asynchronous read ports, one
// synchronous write port, asynchronous active-low clear. x0 is hardwired 0.
// Optional macro ID_WB_BYPASS_EN: a same-cycle write is forwarded to reads.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_2r1w
  import id_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [REG_AW-1:0] i_raddr1,
  input  wire logic [REG_AW-1:0] i_raddr2,
  output logic      [XLEN-1:0]   o_rdata1,
  output logic      [XLEN-1:0]   o_rdata2,
  input  wire logic              i_we,
  input  wire logic [REG_AW-1:0] i_waddr,
  input  wire logic [XLEN-1:0]   i_wdata
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Write port; index 0 is never written so it stays at its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports, optionally forwarding the write happening this cycle
  always_comb begin
    o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef ID_WB_BYPASS_EN
    if (i_we && (i_waddr != '0) && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
    if (i_we && (i_waddr != '0) && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`else
    // Writeback-to-decode hazards are resolved outside this stage
`endif
  end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
//------------------------------------------------------------------------------
// id_stage
// RV32I decode stage: register-file read, control/immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
// Optional macro ID_WB_BYPASS_EN (handled in regfile_2r1w) forwards a
// same-cycle writeback into the operand read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_stage
  import id_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,      // asynchronous, active-low
  id_stage_if.slave bus
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_f7b5;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [XLEN-1:0]   w_rs1_data;
  logic [XLEN-1:0]   w_rs2_data;
  imm_type_e         w_imm_type;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_hazard;
  idex_t             w_dec;
  idex_t             r_idex;

  assign w_opcode = bus.instruction[6:0];
  assign w_funct3 = bus.instruction[14:12];
  assign w_f7b5   = bus.instruction[30];
  assign w_rd     = bus.instruction[11:7];
  assign w_rs1    = bus.instruction[19:15];
  assign w_rs2    = bus.instruction[24:20];

  regfile_2r1w u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_rd),
    .i_wdata  (bus.wb_data)
  );

  // Combinational decode of the fetched instruction into an ID/EX record
  always_comb begin
    w_dec          = c_BUBBLE;
    w_imm_type     = IMM_NONE;
    w_use_rs1      = 1'b0;
    w_use_rs2      = 1'b0;
    w_dec.valid    = 1'b1;
    w_dec.pc       = bus.pc_in;
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.rd       = w_rd;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.alu_op   = ALU_ADD;

    case (w_opcode)
      c_OP_LUI: begin
        w_imm_type      = IMM_U;
        w_dec.alu_op    = ALU_PASSB;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      c_OP_AUIPC: begin
        w_imm_type      = IMM_U;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      c_OP_JAL: begin
        w_imm_type      = IMM_J;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
      end
      c_OP_JALR: begin
        w_imm_type      = IMM_I;
        w_use_rs1       = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
      end
      c_OP_BRANCH: begin
        // The ALU produces the comparison; signedness follows funct3
        w_imm_type   = IMM_B;
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
        w_dec.branch = 1'b1;
        case (w_funct3[2:1])
          2'b10:   w_dec.alu_op = ALU_SLT;
          2'b11:   w_dec.alu_op = ALU_SLTU;
          default: w_dec.alu_op = ALU_SUB;
        endcase
      end
      c_OP_LOAD: begin
        w_imm_type      = IMM_I;
        w_use_rs1       = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.mem_read  = 1'b1;
      end
      c_OP_STORE: begin
        w_imm_type      = IMM_S;
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      c_OP_OPIMM: begin
        w_imm_type      = IMM_I;
        w_use_rs1       = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = alu_from_funct(w_funct3, w_f7b5, 1'b0);
      end
      c_OP_OP: begin
        w_use_rs1       = 1'b1;
        w_use_rs2       = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.alu_op    = alu_from_funct(w_funct3, w_f7b5, 1'b1);
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase

    w_dec.imm = gen_imm(bus.instruction, w_imm_type);

    // All-zero instruction is a fetch bubble, not an illegal opcode
    if (bus.instruction == '0) begin
      w_dec     = c_BUBBLE;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
    end
  end

  // Load in ID/EX whose destination feeds a source this instruction reads
  always_comb begin
    w_hazard = r_idex.valid && r_idex.mem_read && (r_idex.rd != '0) &&
               ((w_use_rs1 && (r_idex.rd == w_rs1)) ||
                (w_use_rs2 && (r_idex.rd == w_rs2)));
  end

  // ID/EX register: flush beats stall, stall beats hazard bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idex <= c_BUBBLE;
    end else if (bus.flush_in) begin
      r_idex <= c_BUBBLE;
    end else if (bus.stall_in) begin
      r_idex <= r_idex;
    end else if (w_hazard) begin
      r_idex <= c_BUBBLE;
    end else begin
      r_idex <= w_dec;
    end
  end

  assign bus.hazard_stall = w_hazard;
  assign bus.id_valid     = r_idex.valid;
  assign bus.id_pc        = r_idex.pc;
  assign bus.rs1_data     = r_idex.rs1_data;
  assign bus.rs2_data     = r_idex.rs2_data;
  assign bus.imm          = r_idex.imm;
  assign bus.rd           = r_idex.rd;
  assign bus.rs1          = r_idex.rs1;
  assign bus.rs2          = r_idex.rs2;
  assign bus.alu_op       = r_idex.alu_op;
  assign bus.alu_src      = r_idex.alu_src;
  assign bus.reg_write    = r_idex.reg_write;
  assign bus.mem_read     = r_idex.mem_read;
  assign bus.mem_write    = r_idex.mem_write;
  assign bus.branch       = r_idex.branch;
  assign bus.jump         = r_idex.jump;
  assign bus.illegal      = r_idex.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
//------------------------------------------------------------------------------
// tb_id_stage
// Directed self-checking bench for id_stage with hand-computed expectations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_stage;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  id_stage_if bus_if ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr);
    bus_if.instruction = instr;
    bus_if.pc_in       = bus_if.pc_in + 32'd4;
  endtask

  logic [31:0] exp_byp;

  initial begin
    n_total = 0;
    n_bad   = 0;
    bus_if.pc_in       = 32'h0000_00FC;
    bus_if.instruction = 32'h0;
    bus_if.stall_in    = 1'b0;
    bus_if.flush_in    = 1'b0;
    bus_if.wb_en       = 1'b0;
    bus_if.wb_rd       = 5'd0;
    bus_if.wb_data     = 32'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    check("reset_valid", 32'(bus_if.id_valid), 32'd0);
    check("reset_imm", bus_if.imm, 32'd0);

    // addi x1,x0,5 out of reset
    drive(32'h0050_0093);      // pc = 0x100
    @(negedge clk);
    reset = 1'b1;
    step();
    check("addi_valid", 32'(bus_if.id_valid), 32'd1);
    check("addi_rd", 32'(bus_if.rd), 32'd1);
    check("addi_rs1", 32'(bus_if.rs1), 32'd0);
    check("addi_imm", bus_if.imm, 32'd5);
    check("addi_aluop", 32'(bus_if.alu_op), 32'd0);
    check("addi_alusrc", 32'(bus_if.alu_src), 32'd1);
    check("addi_regwr", 32'(bus_if.reg_write), 32'd1);
    check("addi_pc", bus_if.id_pc, 32'h0000_0100);

    // asynchronous reset clears outputs without a clock edge
    #2 reset = 1'b0;
    #1;
    check("areset_valid", 32'(bus_if.id_valid), 32'd0);
    check("areset_imm", bus_if.imm, 32'd0);
    check("areset_rd", 32'(bus_if.rd), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // write x1 = 0x1234, then add x3,x1,x2
    bus_if.instruction = 32'h0;
    bus_if.wb_en = 1'b1; bus_if.wb_rd = 5'd1; bus_if.wb_data = 32'h1234;
    step();
    bus_if.wb_en = 1'b0;
    drive(32'h0020_81B3);
    step();
    check("add_rs1data", bus_if.rs1_data, 32'h1234);
    check("add_rs2data", bus_if.rs2_data, 32'h0);
    check("add_aluop", 32'(bus_if.alu_op), 32'd0);
    check("add_rd", 32'(bus_if.rd), 32'd3);
    check("add_alusrc", 32'(bus_if.alu_src), 32'd0);

    // writes to x0 are dropped
    bus_if.instruction = 32'h0;
    bus_if.wb_en = 1'b1; bus_if.wb_rd = 5'd0; bus_if.wb_data = 32'hFFFF_FFFF;
    step();
    bus_if.wb_en = 1'b0;
    drive(32'h0000_0033);      // add x0,x0,x0
    step();
    check("x0_rs1data", bus_if.rs1_data, 32'h0);
    check("x0_valid", 32'(bus_if.id_valid), 32'd1);

    // immediate formats and ALU op selection
    drive(32'hFFF0_0113);      // addi x2,x0,-1
    step();
    check("iimm_neg", bus_if.imm, 32'hFFFF_FFFF);
    drive(32'hFE00_0EE3);      // beq x0,x0,-4
    step();
    check("bimm", bus_if.imm, 32'hFFFF_FFFC);
    check("beq_branch", 32'(bus_if.branch), 32'd1);
    check("beq_regwr", 32'(bus_if.reg_write), 32'd0);
    drive(32'h0080_00EF);      // jal x1,8
    step();
    check("jimm", bus_if.imm, 32'd8);
    check("jal_jump", 32'(bus_if.jump), 32'd1);
    drive(32'h1234_50B7);      // lui x1,0x12345
    step();
    check("uimm", bus_if.imm, 32'h1234_5000);
    check("lui_aluop", 32'(bus_if.alu_op), 32'd10);
    drive(32'h4020_8233);      // sub x4,x1,x2
    step();
    check("sub_aluop", 32'(bus_if.alu_op), 32'd1);
    drive(32'h4010_D093);      // srai x1,x1,1
    step();
    check("srai_aluop", 32'(bus_if.alu_op), 32'd7);
    drive(32'h4000_0093);      // addi x1,x0,1024: bit30 set but still ADD
    step();
    check("addi_b30_aluop", 32'(bus_if.alu_op), 32'd0);

    // same-cycle writeback and read of x1 (x1 currently 0x1234)
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'h0000_CAFE;
`else
    exp_byp = 32'h0000_1234;
`endif
    bus_if.wb_en = 1'b1; bus_if.wb_rd = 5'd1; bus_if.wb_data = 32'h0000_CAFE;
    drive(32'h0020_81B3);
    step();
    check("bypass_rs1data", bus_if.rs1_data, exp_byp);
    bus_if.wb_en = 1'b0;
    step();
    check("after_wr_rs1data", bus_if.rs1_data, 32'h0000_CAFE);

    // load followed by an I-type whose rs2 field collides: no hazard
    drive(32'h0000_A283);      // lw x5,0(x1)
    step();
    check("lw_memread", 32'(bus_if.mem_read), 32'd1);
    check("lw_rd", 32'(bus_if.rd), 32'd5);
    drive(32'h0050_0393);      // addi x7,x0,5
    #1;
    check("no_hazard_itype", 32'(bus_if.hazard_stall), 32'd0);

    // load-use: exactly one bubble
    drive(32'h0000_A283);      // lw x5,0(x1) (replaces addi before the edge)
    step();
    drive(32'h0012_8333);      // add x6,x5,x1
    #1;
    check("lu_hazard", 32'(bus_if.hazard_stall), 32'd1);
    step();
    check("lu_bubble_valid", 32'(bus_if.id_valid), 32'd0);
    check("lu_hazard_drop", 32'(bus_if.hazard_stall), 32'd0);
    step();
    check("lu_add_valid", 32'(bus_if.id_valid), 32'd1);
    check("lu_add_rs1", 32'(bus_if.rs1), 32'd5);
    check("lu_add_rd", 32'(bus_if.rd), 32'd6);

    // flush wins over stall
    bus_if.flush_in = 1'b1; bus_if.stall_in = 1'b1;
    step();
    check("flush_valid", 32'(bus_if.id_valid), 32'd0);
    bus_if.flush_in = 1'b0; bus_if.stall_in = 1'b0;
    drive(32'h0020_81B3);
    step();
    check("refill_rd", 32'(bus_if.rd), 32'd3);

    // stall alone holds outputs for three edges
    bus_if.stall_in = 1'b1;
    drive(32'hFFF0_0113);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_rd", 32'(bus_if.rd), 32'd3);
      check("stall_imm", bus_if.imm, 32'h0);
      check("stall_valid", 32'(bus_if.id_valid), 32'd1);
    end
    bus_if.stall_in = 1'b0;

    // bubble and illegal opcode
    bus_if.instruction = 32'h0;
    step();
    check("bubble_valid", 32'(bus_if.id_valid), 32'd0);
    check("bubble_illegal", 32'(bus_if.illegal), 32'd0);
    drive(32'h0000_007F);
    step();
    check("illegal_valid", 32'(bus_if.id_valid), 32'd1);
    check("illegal_flag", 32'(bus_if.illegal), 32'd1);
    check("illegal_regwr", 32'(bus_if.reg_write), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
